cache_controller: RTL

Control FSM for the direct-mapped, write-through data cache. It is the stage directly upstream of the valid-bit RAM and the tag/data RAMs, and drives their index, write enables and write data. It services CPU read/write requests and performs tag compare, line fill on read miss, and write-through to main memory with a fixed wait-state count.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/mem_wait_counter.sv | 29 ++
 rtl/cache_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths, encodings and FSM state type for the direct-mapped,
// write-through data cache controller.
package cache_pkg;

  localparam int ADDR_W              = 16;
  localparam int INDEX_W             = 10;
  localparam int TAG_W               = ADDR_W - INDEX_W;
  localparam int DATA_W              = 32;
  localparam int CACHESIZE           = 1024;
  localparam int WAIT_STATES_DEFAULT = 2;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    MEM_WAIT,
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Main-memory wait-state counter: loads WAIT_STATES, counts down, flags zero.
module mem_wait_counter #(
  parameter int WAIT_STATES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WAIT_STATES);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cache_controller.sv
// Control FSM for the direct-mapped, write-through data cache: tag compare,
// read-miss line fill and write-through with a fixed main-memory wait count.
module cache_controller
  import cache_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PStrobe,
  input  logic               PRW,
  input  logic [ADDR_W-1:0]  PAddress,
  input  logic [DATA_W-1:0]  PDataIn,
  output logic [DATA_W-1:0]  PDataOut,
  output logic               PReady,
  output logic [INDEX_W-1:0] CacheIndex,
  input  logic               ValidOut,
  input  logic [TAG_W-1:0]   TagOut,
  input  logic [DATA_W-1:0]  CacheDataOut,
  output logic               ValidIn,
  output logic               ValidWrite,
  output logic [TAG_W-1:0]   TagIn,
  output logic               TagWrite,
  output logic [DATA_W-1:0]  CacheDataIn,
  output logic               DataWrite,
  output logic               SysStrobe,
  output logic               SysRW,
  output logic [ADDR_W-1:0]  SysAddress,
  output logic [DATA_W-1:0]  SysDataOut,
  input  logic [DATA_W-1:0]  SysDataIn
);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  addr_q;
  logic               rw_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               hit_q;
  logic               hit;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [TAG_W-1:0]   tag;

  assign tag        = addr_q[ADDR_W-1:INDEX_W];
  assign CacheIndex = addr_q[INDEX_W-1:0];
  assign PDataOut   = rdata_q;
  assign hit        = ValidOut && (TagOut == tag);

  mem_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .Clk  (Clk),
    .Reset(Reset),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && PStrobe) begin
        addr_q  <= PAddress;
        rw_q    <= PRW;
        wdata_q <= PDataIn;
      end
      if (state == COMPARE) begin
        hit_q <= hit;
        if (rw_q == READ) rdata_q <= CacheDataOut;
      end
      // Read-miss data is taken on the closing edge of the last wait cycle.
      if ((state == MEM_WAIT) && cnt_zero && (rw_q == READ)) rdata_q <= SysDataIn;
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_next  = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    PReady      = 1'b0;
    ValidIn     = 1'b0;
    ValidWrite  = 1'b0;
    TagIn       = '0;
    TagWrite    = 1'b0;
    CacheDataIn = '0;
    DataWrite   = 1'b0;
    SysStrobe   = 1'b0;
    SysRW       = 1'b0;
    SysAddress  = '0;
    SysDataOut  = '0;
    case (state)
      IDLE:    if (PStrobe) state_next = LOOKUP;
      LOOKUP:  state_next = COMPARE;
      COMPARE: begin
        if ((rw_q == READ) && hit) begin
          state_next = DONE;
        end else begin
          state_next = MEM_WAIT;
          cnt_load   = 1'b1;
        end
      end
      MEM_WAIT: begin
        SysStrobe  = 1'b1;
        SysRW      = rw_q;
        SysAddress = addr_q;
        if (rw_q == WRITE) SysDataOut = wdata_q;
        if (cnt_zero) state_next = FILL;
        else          cnt_dec    = 1'b1;
      end
      FILL: begin
        state_next = DONE;
        if (rw_q == READ) begin
          ValidWrite  = 1'b1;
          TagWrite    = 1'b1;
          DataWrite   = 1'b1;
          ValidIn     = 1'b1;
          TagIn       = tag;
          CacheDataIn = rdata_q;
        end else if (hit_q) begin
          // Write hit updates the data word only; write misses do not allocate.
          DataWrite   = 1'b1;
          CacheDataIn = wdata_q;
        end
      end
      DONE: begin
        PReady     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (Reset) begin
      PReady     = 1'b0;
      ValidWrite = 1'b0;
      TagWrite   = 1'b0;
      DataWrite  = 1'b0;
    end
  end

endmodule
